// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selector and load-use / RAW stall controller sitting at the
// ID/EXE boundary, with saturating stall and forward statistics.
module fwd_hazard_unit #(
  parameter int REG_AW     = 4,
  parameter int NUM_SRC    = 3,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = 2,
  parameter int LOAD_LAT   = 1,
  parameter int NOFWD_EN   = 1,
  parameter int NOFWD_ADDR = 15,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         forward_en,
  input  logic                         flush,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    src_addr,
  input  logic [NUM_STAGES-1:0]        stage_wb_en,
  input  logic [NUM_STAGES*REG_AW-1:0] stage_dst,
  input  logic                         exe_wb_en,
  input  logic                         exe_mem_read,
  input  logic [REG_AW-1:0]            exe_dst,
  output logic [NUM_SRC*SEL_W-1:0]     sel,
  output logic                         stall,
  input  logic                         clr_stats,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             fwd_cnt
);

  localparam logic [REG_AW-1:0] NOFWD_A   = REG_AW'(NOFWD_ADDR);
  localparam logic [3:0]        LAT_START = 4'(LOAD_LAT - 1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       lat_q, lat_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] fwd_cnt_q, fwd_cnt_d;

  logic [NUM_SRC-1:0] exe_hit;    // EXE writes this source, load or not
  logic [NUM_SRC-1:0] load_hit;   // EXE is a load writing this source
  logic [NUM_SRC-1:0] stage_any;  // some forwarding stage writes this source

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_AW-1:0]     addr;
    logic                  src_ok;
    logic [NUM_STAGES-1:0] hit;
    logic [SEL_W-1:0]      sel_raw;

    assign addr   = src_addr[i*REG_AW +: REG_AW];
    // The PC reads as a computed value, never from a pipeline result.
    assign src_ok = src_valid[i] & ~((NOFWD_EN != 0) && (addr == NOFWD_A));

    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
      assign hit[s] = src_ok & stage_wb_en[s] & (addr == stage_dst[s*REG_AW +: REG_AW]);
    end

    assign exe_hit[i]   = src_ok & exe_wb_en & (addr == exe_dst);
    assign load_hit[i]  = exe_hit[i] & exe_mem_read;
    assign stage_any[i] = |hit;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
      sel_raw = '0;
      for (int s = NUM_STAGES - 1; s >= 0; s--) begin
        if (hit[s]) sel_raw = SEL_W'(s + 1);
      end
    end

    assign sel[i*SEL_W +: SEL_W] = forward_en ? sel_raw : '0;
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    stall   = 1'b0;
    if (flush) begin
      state_d = IDLE;
      lat_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (forward_en) begin
            if (|load_hit) begin
              stall = 1'b1;
              if (LOAD_LAT > 1) begin
                state_d = WAIT;
                lat_d   = LAT_START;
              end
            end
          end else begin
            stall = |(exe_hit | stage_any);
          end
        end
        WAIT: begin
          // The remaining bubbles are owed regardless of forward_en or EXE contents.
          stall = 1'b1;
          lat_d = lat_q - 4'd1;
          if (lat_q == 4'd1) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          lat_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (clr_stats) begin
      stall_cnt_d = '0;
      fwd_cnt_d   = '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (!stall && (|sel) && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

endmodule
